// File: rtl/column_bank_scheduler.sv
`timescale 1ns/1ps
// column_bank_scheduler
// Triple-buffer manager for the three column-data banks that feed the VGA
// pixel pipeline. One bank is read by the display, one is filled by software,
// and at most one completed frame waits for vertical blank.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   wr_col_valid            pulse: assembled column on wr_coldata/wr_sfdata
//   wr_coldata, wr_sfdata   column payload and texture scale factor
//   wr_restart              pulse: restart current frame at column 0
//   vblank_start            display marker; only its rising edge is used
//   bank_we                 one-hot write strobe per bank
//   bank_wr_colnum          column address of the write
//   bank_coldata/sfdata     registered payload for the write
//   rd_bank, wr_bank        bank indices for display and writer
//   display_valid           a completed frame has been shown since reset
//   frame_pending           a READY bank waits for vblank
//   frames_dropped          saturating count of overwritten READY frames
module column_bank_scheduler #(
  parameter int unsigned NCOLS = 640,
  parameter int unsigned COLW  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_col_valid,
  input  logic [41:0]     wr_coldata,
  input  logic [15:0]     wr_sfdata,
  input  logic            wr_restart,
  input  logic            vblank_start,
  output logic [2:0]      bank_we,
  output logic [COLW-1:0] bank_wr_colnum,
  output logic [41:0]     bank_coldata,
  output logic [15:0]     bank_sfdata,
  output logic [1:0]      rd_bank,
  output logic [1:0]      wr_bank,
  output logic            display_valid,
  output logic            frame_pending,
  output logic [7:0]      frames_dropped
);

  localparam int unsigned NBANK = 3;
  localparam int unsigned CDW   = 42;
  localparam int unsigned SFW   = 16;
  localparam int unsigned BIDXW = 2;
  localparam int unsigned DROPW = 8;

  typedef enum logic [1:0] {
    B_FREE    = 2'd0,
    B_FILLING = 2'd1,
    B_READY   = 2'd2,
    B_DISPLAY = 2'd3
  } bank_st_e;

  bank_st_e            st_q [NBANK];
  bank_st_e            st_d [NBANK];
  logic [COLW-1:0]     col_q, col_d;
  logic [DROPW-1:0]    drop_q, drop_d;
  logic                dv_q, dv_d;
  logic                vb_q, vb_d;

  logic [NBANK-1:0]    we_q, we_d;
  logic [COLW-1:0]     colnum_q, colnum_d;
  logic [CDW-1:0]      coldata_q, coldata_d;
  logic [SFW-1:0]      sfdata_q, sfdata_d;
  logic [BIDXW-1:0]    rd_bank_q, rd_bank_d;
  logic [BIDXW-1:0]    wr_bank_q, wr_bank_d;
  logic                fp_q, fp_d;

  // Restart discards a coincident column.
  logic col_wr_c;
  logic complete_c;
  logic vb_rise_c;

  assign col_wr_c   = wr_col_valid & ~wr_restart;
  assign complete_c = col_wr_c & (col_q == COLW'(NCOLS - 1));
  assign vb_rise_c  = vblank_start & ~vb_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q[0]   <= B_DISPLAY;
      st_q[1]   <= B_FILLING;
      st_q[2]   <= B_FREE;
      col_q     <= '0;
      drop_q    <= '0;
      dv_q      <= 1'b0;
      vb_q      <= 1'b0;
      we_q      <= '0;
      colnum_q  <= '0;
      coldata_q <= '0;
      sfdata_q  <= '0;
      rd_bank_q <= BIDXW'(0);
      wr_bank_q <= BIDXW'(1);
      fp_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NBANK; i++) begin
        st_q[i] <= st_d[i];
      end
      col_q     <= col_d;
      drop_q    <= drop_d;
      dv_q      <= dv_d;
      vb_q      <= vb_d;
      we_q      <= we_d;
      colnum_q  <= colnum_d;
      coldata_q <= coldata_d;
      sfdata_q  <= sfdata_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      fp_q      <= fp_d;
    end
  end

  // Next-state: completion first, then swap, then writer picks a FREE bank.
  always_comb begin
    logic drop_inc;
    logic have_ready;
    logic found;
    for (int unsigned i = 0; i < NBANK; i++) begin
      st_d[i] = st_q[i];
    end
    col_d      = col_q;
    drop_d     = drop_q;
    dv_d       = dv_q;
    vb_d       = vblank_start;
    drop_inc   = 1'b0;
    have_ready = 1'b0;
    found      = 1'b0;

    if (complete_c) begin
      for (int unsigned i = 0; i < NBANK; i++) begin
        if (st_q[i] == B_READY) begin
          st_d[i]  = B_FREE;
          drop_inc = 1'b1;
        end
      end
      for (int unsigned i = 0; i < NBANK; i++) begin
        if (wr_bank_q == BIDXW'(i)) begin
          st_d[i] = B_READY;
        end
      end
    end

    for (int unsigned i = 0; i < NBANK; i++) begin
      if (st_d[i] == B_READY) begin
        have_ready = 1'b1;
      end
    end

    // The old DISPLAY bank is never READY, so both updates are disjoint.
    if (vb_rise_c && have_ready) begin
      for (int unsigned i = 0; i < NBANK; i++) begin
        if (st_q[i] == B_DISPLAY) begin
          st_d[i] = B_FREE;
        end else if (st_d[i] == B_READY) begin
          st_d[i] = B_DISPLAY;
        end
      end
      dv_d = 1'b1;
    end

    // Three banks, one DISPLAY and at most one READY: a FREE bank exists.
    if (complete_c) begin
      for (int unsigned i = 0; i < NBANK; i++) begin
        if (!found && st_d[i] == B_FREE) begin
          st_d[i] = B_FILLING;
          found   = 1'b1;
        end
      end
    end

    if (wr_restart) begin
      col_d = '0;
    end else if (col_wr_c) begin
      col_d = complete_c ? '0 : col_q + COLW'(1);
    end

    if (drop_inc && (drop_q != {DROPW{1'b1}})) begin
      drop_d = drop_q + DROPW'(1);
    end
  end

  // Output decode: write strobe for the current bank, status from next state.
  always_comb begin
    we_d      = '0;
    colnum_d  = colnum_q;
    coldata_d = coldata_q;
    sfdata_d  = sfdata_q;
    rd_bank_d = rd_bank_q;
    wr_bank_d = wr_bank_q;
    fp_d      = 1'b0;

    if (col_wr_c) begin
      for (int unsigned i = 0; i < NBANK; i++) begin
        if (wr_bank_q == BIDXW'(i)) begin
          we_d[i] = 1'b1;
        end
      end
      colnum_d  = col_q;
      coldata_d = wr_coldata;
      sfdata_d  = wr_sfdata;
    end

    for (int unsigned i = 0; i < NBANK; i++) begin
      if (st_d[i] == B_DISPLAY) begin
        rd_bank_d = BIDXW'(i);
      end
      if (st_d[i] == B_FILLING) begin
        wr_bank_d = BIDXW'(i);
      end
      if (st_d[i] == B_READY) begin
        fp_d = 1'b1;
      end
    end
  end

  assign bank_we        = we_q;
  assign bank_wr_colnum = colnum_q;
  assign bank_coldata   = coldata_q;
  assign bank_sfdata    = sfdata_q;
  assign rd_bank        = rd_bank_q;
  assign wr_bank        = wr_bank_q;
  assign display_valid  = dv_q;
  assign frame_pending  = fp_q;
  assign frames_dropped = drop_q;

endmodule

// File: tb/tb_column_bank_scheduler.sv
`timescale 1ns/1ps
// Bench for column_bank_scheduler: write strobes are scoreboarded by a
// negedge monitor; bank status is checked against hand-derived values.
module tb_column_bank_scheduler;

  localparam int unsigned NCOLS = 640;

  typedef struct packed {
    logic [2:0]  we;
    logic [9:0]  col;
    logic [41:0] cd;
    logic [15:0] sf;
  } wr_t;

  logic        clk;
  logic        reset, wr_col_valid, wr_restart, vblank_start;
  logic [41:0] wr_coldata;
  logic [15:0] wr_sfdata;
  logic [2:0]  bank_we;
  logic [9:0]  bank_wr_colnum;
  logic [41:0] bank_coldata;
  logic [15:0] bank_sfdata;
  logic [1:0]  rd_bank, wr_bank;
  logic        display_valid, frame_pending;
  logic [7:0]  frames_dropped;

  // Small-frame instance used for drop-counter saturation.
  logic        s_reset, s_valid;
  logic [2:0]  s_we;
  logic [9:0]  s_colnum;
  logic [41:0] s_cd;
  logic [15:0] s_sf;
  logic [1:0]  s_rd, s_wr;
  logic        s_dv, s_fp;
  logic [7:0]  s_drop;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];

  column_bank_scheduler #(.NCOLS(NCOLS), .COLW(10)) dut (
    .clk(clk), .reset(reset), .wr_col_valid(wr_col_valid),
    .wr_coldata(wr_coldata), .wr_sfdata(wr_sfdata), .wr_restart(wr_restart),
    .vblank_start(vblank_start), .bank_we(bank_we),
    .bank_wr_colnum(bank_wr_colnum), .bank_coldata(bank_coldata),
    .bank_sfdata(bank_sfdata), .rd_bank(rd_bank), .wr_bank(wr_bank),
    .display_valid(display_valid), .frame_pending(frame_pending),
    .frames_dropped(frames_dropped)
  );

  column_bank_scheduler #(.NCOLS(4), .COLW(10)) dut_small (
    .clk(clk), .reset(s_reset), .wr_col_valid(s_valid),
    .wr_coldata(42'd0), .wr_sfdata(16'd0), .wr_restart(1'b0),
    .vblank_start(1'b0), .bank_we(s_we), .bank_wr_colnum(s_colnum),
    .bank_coldata(s_cd), .bank_sfdata(s_sf), .rd_bank(s_rd), .wr_bank(s_wr),
    .display_valid(s_dv), .frame_pending(s_fp), .frames_dropped(s_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One column to 'bank' at 'col'; expected strobe goes to the scoreboard.
  task automatic send_col(input int bank, input int col);
    logic [63:0] r;
    wr_t e;
    r = {$urandom(), $urandom()};
    wr_coldata   = r[41:0];
    wr_sfdata    = r[57:42];
    wr_col_valid = 1'b1;
    e.we  = 3'(1 << bank);
    e.col = 10'(col);
    e.cd  = r[41:0];
    e.sf  = r[57:42];
    exp_q.push_back(e);
    tick();
    wr_col_valid = 1'b0;
  endtask

  task automatic send_cols(input int bank, input int from, input int to);
    for (int c = from; c <= to; c++) send_col(bank, c);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_we"},     64'(bank_we), 64'(0));
    chk({tag, "_colnum"}, 64'(bank_wr_colnum), 64'(0));
    chk({tag, "_cd"},     64'(bank_coldata), 64'(0));
    chk({tag, "_sf"},     64'(bank_sfdata), 64'(0));
    chk({tag, "_rd"},     64'(rd_bank), 64'(0));
    chk({tag, "_wr"},     64'(wr_bank), 64'(1));
    chk({tag, "_dv"},     64'(display_valid), 64'(0));
    chk({tag, "_fp"},     64'(frame_pending), 64'(0));
    chk({tag, "_drop"},   64'(frames_dropped), 64'(0));
  endtask

  task automatic vb_pulse();
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bank_we !== 3'b000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_we", 64'(bank_we), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("we",     64'(bank_we), 64'(e.we));
          chk("colnum", 64'(bank_wr_colnum), 64'(e.col));
          chk("coldata", 64'(bank_coldata), 64'(e.cd));
          chk("sfdata", 64'(bank_sfdata), 64'(e.sf));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; wr_col_valid = 1'b0; wr_restart = 1'b0; vblank_start = 1'b0;
    wr_coldata = '0; wr_sfdata = '0;
    s_reset = 1'b1; s_valid = 1'b0;
    repeat (3) tick();
    check_reset("rst");
    reset = 1'b0; s_reset = 1'b0;

    // Single frame into bank1, then swap.
    send_cols(1, 0, NCOLS - 1);
    chk("f1_wr", 64'(wr_bank), 64'(2));
    chk("f1_fp", 64'(frame_pending), 64'(1));
    chk("f1_rd", 64'(rd_bank), 64'(0));
    chk("f1_dv", 64'(display_valid), 64'(0));
    vb_pulse();
    chk("f1s_rd", 64'(rd_bank), 64'(1));
    chk("f1s_dv", 64'(display_valid), 64'(1));
    chk("f1s_fp", 64'(frame_pending), 64'(0));

    // Drop: two frames with no vblank between.
    reset = 1'b1; repeat (2) tick(); reset = 1'b0;
    send_cols(1, 0, NCOLS - 1);
    send_cols(2, 0, NCOLS - 1);
    chk("drop_cnt", 64'(frames_dropped), 64'(1));
    chk("drop_wr",  64'(wr_bank), 64'(1));
    chk("drop_fp",  64'(frame_pending), 64'(1));
    chk("drop_rd",  64'(rd_bank), 64'(0));
    vb_pulse();
    chk("drops_rd", 64'(rd_bank), 64'(2));
    chk("drops_fp", 64'(frame_pending), 64'(0));

    // Completion and swap together with an older READY bank (bank1).
    send_cols(1, 0, NCOLS - 1);
    chk("sim_pre_wr", 64'(wr_bank), 64'(0));
    send_cols(0, 0, NCOLS - 2);
    vblank_start = 1'b1;
    send_col(0, NCOLS - 1);
    vblank_start = 1'b0;
    chk("sim_rd",   64'(rd_bank), 64'(0));
    chk("sim_drop", 64'(frames_dropped), 64'(2));
    chk("sim_wr",   64'(wr_bank), 64'(1));
    chk("sim_fp",   64'(frame_pending), 64'(0));

    // Restart together with a column: column discarded, counter to 0.
    send_cols(1, 0, 99);
    wr_restart = 1'b1; wr_col_valid = 1'b1;
    tick();
    wr_restart = 1'b0; wr_col_valid = 1'b0;
    send_col(1, 0);
    chk("rs_wr", 64'(wr_bank), 64'(1));
    send_cols(1, 1, NCOLS - 1);
    chk("rs_done_wr", 64'(wr_bank), 64'(2));
    chk("rs_done_fp", 64'(frame_pending), 64'(1));

    // vblank held 1600 cycles: one swap, later frame waits for next edge.
    vblank_start = 1'b1;
    tick();
    chk("hold_rd", 64'(rd_bank), 64'(1));
    chk("hold_fp", 64'(frame_pending), 64'(0));
    send_cols(2, 0, NCOLS - 1);
    chk("hold2_fp", 64'(frame_pending), 64'(1));
    chk("hold2_wr", 64'(wr_bank), 64'(0));
    repeat (1600 - 1 - NCOLS) tick();
    chk("hold3_rd", 64'(rd_bank), 64'(1));
    chk("hold3_fp", 64'(frame_pending), 64'(1));
    vblank_start = 1'b0;
    tick();
    vb_pulse();
    chk("hold4_rd", 64'(rd_bank), 64'(2));
    chk("hold4_fp", 64'(frame_pending), 64'(0));

    // Reset mid-frame, with a column offered during reset.
    send_cols(0, 0, 49);
    tick();
    reset = 1'b1; wr_col_valid = 1'b1;
    tick();
    chk("mid_rst_we", 64'(bank_we), 64'(0));
    tick();
    check_reset("mid_rst");
    wr_col_valid = 1'b0; reset = 1'b0;
    send_col(1, 0);
    chk("post_rst_wr", 64'(wr_bank), 64'(1));

    // Saturation: 302 four-column frames give 301 drops.
    s_valid = 1'b1;
    repeat (302 * 4) tick();
    s_valid = 1'b0;
    tick();
    chk("sat_drop", 64'(s_drop), 64'(255));
    s_reset = 1'b1;
    tick();
    chk("sat_rst_drop", 64'(s_drop), 64'(0));
    chk("sat_rst_wr",   64'(s_wr), 64'(1));
    s_reset = 1'b0;

    repeat (3) tick();
    chk("pending_writes", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/column_bank_scheduler.md
# column_bank_scheduler

Triple-buffer scheduler for the three column-data banks that feed the VGA pixel pipeline. It assigns one bank to the display reader, one to the software writer, and holds at most one completed frame pending. Banks swap only at the start of vertical blank. It generates the per-bank write strobes and column addresses, and reports status for the Avalon readdata path. It sits between the Avalon column-write assembler (upstream) and the bank memories / pixel pipeline (downstream).

## Interface
- NCOLS, 640, columns per frame; last column index is NCOLS-1.
- COLW, 10, column index width.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- wr_col_valid  in  1  one-cycle pulse: a fully assembled column is presented on wr_coldata/wr_sfdata.
- wr_coldata  in  42  column data {top[15:0], height[15:0], dir, tex_type[2:0], tex_col[5:0]}.
- wr_sfdata  in  16  texture scaling factor for the column.
- wr_restart  in  1  pulse: restart the current frame at column 0, in the same bank.
- vblank_start  in  1  display-side marker at vcount==480; may be high for more than one cycle.
- bank_we  out  3  one-hot write strobe, one bit per bank.
- bank_wr_colnum  out  COLW  column address for the write.
- bank_coldata  out  42  registered copy of wr_coldata.
- bank_sfdata  out  16  registered copy of wr_sfdata.
- rd_bank  out  2  bank index (0..2) the pixel pipeline reads.
- wr_bank  out  2  bank index currently being filled.
- display_valid  out  1  high once the first completed frame has been displayed.
- frame_pending  out  1  a READY bank is waiting for vblank.
- frames_dropped  out  8  count of READY frames overwritten before display; saturates at 255.

## Operation
- Each bank is in one of four states: FREE, FILLING, READY or DISPLAY.
- Invariants: exactly one bank is DISPLAY; exactly one is FILLING; at most one is READY.
- Reset state:
  - bank0 DISPLAY, bank1 FILLING, bank2 FREE.
  - Write column counter = 0; rd_bank=0, wr_bank=1.
  - bank_we=0, bank_wr_colnum=0, bank_coldata=0, bank_sfdata=0.
  - display_valid=0, frame_pending=0, frames_dropped=0.
  - The vblank edge-detect register is cleared.
- Column write: on wr_col_valid, the block registers a write to wr_bank at the current counter value, then increments the counter.
- Frame completion, when wr_col_valid arrives with counter==NCOLS-1:
  - Counter wraps to 0.
  - The FILLING bank becomes READY.
  - If a READY bank already existed, it becomes FREE and frames_dropped increments (saturating).
  - The writer takes the lowest-index FREE bank as the new FILLING bank.
- Swap, on a vblank_start rising edge (high this cycle, low the previous cycle) while a READY bank exists:
  - READY becomes DISPLAY; the old DISPLAY bank becomes FREE.
  - display_valid is set and remains set until reset.
  - If no bank is READY, nothing changes.
- Completion and swap in the same cycle:
  - The just-completed bank goes directly to DISPLAY.
  - Any older READY bank becomes FREE and counts as dropped.
  - The old DISPLAY bank becomes FREE.
  - The writer takes the lowest-index FREE bank.
- wr_restart: counter returns to 0; bank states are unchanged. If wr_restart and wr_col_valid are asserted together, restart wins: the column is discarded, bank_we stays 0 and the counter becomes 0.
- vblank_start held high for many cycles causes exactly one swap attempt.
- frame_pending = (some bank is READY), taken from registered state.

## Timing
- Write latency is 1 cycle. For wr_col_valid at cycle t:
  - At t+1: bank_we has exactly one bit set (the wr_bank value at t).
  - Also at t+1: bank_wr_colnum holds the counter value at t, and bank_coldata/bank_sfdata hold the input values at t.
  - bank_we is 0 on every other cycle.
- On a completing column at t, the final write strobe at t+1 still targets the old bank. wr_bank shows the new bank from t+1.
- Swap latency: for a rising edge of vblank_start at t, rd_bank, display_valid and frame_pending update at t+1.
- Back-to-back wr_col_valid on every cycle is supported with no stalls. There is no backpressure signal.
- Reset applied mid-frame abandons all state in the cycle after reset is sampled; the partial frame is discarded. bank_we is 0 during reset.

## Test plan
- Single frame: reset, then 640 back-to-back wr_col_valid, then a vblank_start pulse.
  - Writes go to bank1 with colnum 0..639.
  - wr_bank becomes 2 and frame_pending becomes 1.
  - After the pulse: rd_bank=1, display_valid=1, frame_pending=0.
- Drop: fill two frames with no vblank between them.
  - frames_dropped=1, READY bank is 2, wr_bank=1.
  - After vblank: rd_bank=2.
- Simultaneous completion and swap: column 639 and a vblank_start rising edge at the same cycle t, with an older READY bank present.
  - At t+1, rd_bank equals the just-completed bank and frames_dropped increments by 1.
  - The write strobe at t+1 targets the just-completed bank.
- Restart: write 100 columns, pulse wr_restart together with wr_col_valid.
  - No strobe is produced.
  - The next column writes colnum 0 to the same bank.
- vblank_start held high for 1600 cycles with a pending frame: exactly one swap; a second pending frame waits for the next rising edge.
- Saturation and reset: produce 300 drops, check frames_dropped=255; assert reset mid-frame and check every output returns to its reset value.
